// File: rtl/sys_trap_ctrl.sv
// Trap sequencer: arbitrates a synchronous exception, an external interrupt and a timer
// interrupt, drains the pipeline, then issues a one-cycle redirect to mtvec.
module sys_trap_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_vld,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            ext_irq,
    input  logic [63:0]     mtime,
    input  logic [XLEN-1:0] resume_pc,
    input  logic            mret_vld,
    input  logic [XLEN-1:0] mtvec,
    input  logic            cfg_wr,
    input  logic [1:0]      cfg_addr,
    input  logic [XLEN-1:0] cfg_wdata,
    output logic [XLEN-1:0] cfg_rdata,
    output logic            flush_req,
    input  logic            flush_ack,
    output logic            trap_vld,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic            busy
);

    localparam logic [XLEN-1:0] CAUSE_MEI = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] CAUSE_MTI = {1'b1, (XLEN-1)'(7)};

    localparam logic [1:0] ADDR_MSTATUS = 2'd0;
    localparam logic [1:0] ADDR_MIE     = 2'd1;
    localparam logic [1:0] ADDR_CMP_LO  = 2'd2;
    localparam logic [1:0] ADDR_CMP_HI  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mst_mie_q, mst_mie_d;
    logic            mst_mpie_q, mst_mpie_d;
    logic            mie_meie_q, mie_meie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            tip_q;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;

    logic take_ext;
    logic take_tmr;
    logic take_any;

    assign take_ext = mst_mie_q & mie_meie_q & ext_irq;
    assign take_tmr = mst_mie_q & mie_mtie_q & tip_q;
    assign take_any = exc_vld | take_ext | take_tmr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mtimecmp_q <= '1;
            tip_q      <= 1'b0;
            cause_q    <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_meie_q <= mie_meie_d;
            mie_mtie_q <= mie_mtie_d;
            mtimecmp_q <= mtimecmp_d;
            tip_q      <= (mtime >= mtimecmp_q);
            cause_q    <= cause_d;
            epc_q      <= epc_d;
        end
    end

    // Config writes apply first; trap entry and mret then override mstatus bits.
    always_comb begin
        state_d    = state_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_meie_d = mie_meie_q;
        mie_mtie_d = mie_mtie_q;
        mtimecmp_d = mtimecmp_q;
        cause_d    = cause_q;
        epc_d      = epc_q;

        if (cfg_wr) begin
            case (cfg_addr)
                ADDR_MSTATUS: begin
                    mst_mie_d  = cfg_wdata[3];
                    mst_mpie_d = cfg_wdata[7];
                end
                ADDR_MIE: begin
                    mie_mtie_d = cfg_wdata[7];
                    mie_meie_d = cfg_wdata[11];
                end
                ADDR_CMP_LO: mtimecmp_d[31:0]  = cfg_wdata[31:0];
                ADDR_CMP_HI: mtimecmp_d[63:32] = cfg_wdata[31:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (take_any) begin
                    if (exc_vld) begin
                        cause_d = XLEN'(exc_cause);
                        epc_d   = exc_pc;
                    end else if (take_ext) begin
                        cause_d = CAUSE_MEI;
                        epc_d   = resume_pc;
                    end else begin
                        cause_d = CAUSE_MTI;
                        epc_d   = resume_pc;
                    end
                    mst_mpie_d = mst_mie_q;
                    mst_mie_d  = 1'b0;
                    state_d    = S_FLUSH;
                end else if (mret_vld) begin
                    mst_mie_d  = mst_mpie_q;
                    mst_mpie_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_ack) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MSTATUS: begin
                cfg_rdata[3] = mst_mie_q;
                cfg_rdata[7] = mst_mpie_q;
            end
            ADDR_MIE: begin
                cfg_rdata[7]  = mie_mtie_q;
                cfg_rdata[11] = mie_meie_q;
            end
            ADDR_CMP_LO: cfg_rdata = XLEN'(mtimecmp_q[31:0]);
            ADDR_CMP_HI: cfg_rdata = XLEN'(mtimecmp_q[63:32]);
            default: ;
        endcase
    end

    // Handshake outputs decode straight from the state flop so reset drops them at once.
    assign flush_req  = (state_q == S_FLUSH);
    assign trap_vld   = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign trap_pc    = trap_vld ? mtvec   : '0;
    assign trap_cause = trap_vld ? cause_q : '0;
    assign trap_epc   = trap_vld ? epc_q   : '0;

endmodule

// File: tb/tb_sys_trap_ctrl.sv
// Directed bench for sys_trap_ctrl: ecall, timer, priority, masking, busy and reset cases.
module tb_sys_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        exc_vld;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        ext_irq;
    logic [63:0] mtime;
    logic [31:0] resume_pc;
    logic        mret_vld;
    logic [31:0] mtvec;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        flush_req;
    logic        flush_ack;
    logic        trap_vld;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_trap   = 0;
    int nt;
    logic seen;

    sys_trap_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .exc_vld    (exc_vld),
        .exc_cause  (exc_cause),
        .exc_pc     (exc_pc),
        .ext_irq    (ext_irq),
        .mtime      (mtime),
        .resume_pc  (resume_pc),
        .mret_vld   (mret_vld),
        .mtvec      (mtvec),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .trap_vld   (trap_vld),
        .trap_pc    (trap_pc),
        .trap_cause (trap_cause),
        .trap_epc   (trap_epc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trap_vld) n_trap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        cfg_addr = a;
        #1;
        chk(tag, 64'(cfg_rdata), 64'(exp));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wr    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; exc_vld = 1'b0; exc_cause = '0; exc_pc = '0; ext_irq = 1'b0;
        mtime = '0; resume_pc = '0; mret_vld = 1'b0; mtvec = 32'h80;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; flush_ack = 1'b0;
        repeat (2) tick();

        chk("rst_flush_req", flush_req, 0);
        chk("rst_trap_vld", trap_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trap_cause", trap_cause, 0);
        rd(2'd0, 32'h0, "rst_mstatus");
        rd(2'd1, 32'h0, "rst_mie");
        rd(2'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
        rst = 1'b0;
        tick();
        rd(2'd3, 32'hFFFF_FFFF, "rst_cmp_hi");

        // ecall with flush_ack three cycles after flush_req rises
        exc_vld = 1'b1; exc_cause = 4'd11; exc_pc = 32'h100;
        tick();
        exc_vld = 1'b0;
        chk("ecall_flush_req", flush_req, 1);
        chk("ecall_busy", busy, 1);
        tick();
        tick();
        chk("ecall_flush_hold", flush_req, 1);
        chk("ecall_no_early_trap", trap_vld, 0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("ecall_trap_vld", trap_vld, 1);
        chk("ecall_trap_pc", trap_pc, 32'h80);
        chk("ecall_cause", trap_cause, 32'h0000_000B);
        chk("ecall_epc", trap_epc, 32'h100);
        chk("ecall_flush_drop", flush_req, 0);
        tick();
        chk("ecall_trap_end", trap_vld, 0);
        chk("ecall_busy_end", busy, 0);
        chk("ecall_cause_zero", trap_cause, 0);
        chk("ecall_one_trap", n_trap, 1);
        rd(2'd0, 32'h0, "ecall_mstatus");

        // flush_ack while idle has no effect
        flush_ack = 1'b1;
        tick();
        tick();
        flush_ack = 1'b0;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_trap", n_trap, 1);

        // timer: crossing at mtime 0x10, decision a cycle later, flush_req the cycle after
        wr(2'd0, 32'h8);
        wr(2'd1, 32'h80);
        wr(2'd2, 32'h10);
        wr(2'd3, 32'h0);
        resume_pc = 32'h200;
        mtime = 64'h0C;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (flush_req) break;
            mtime = mtime + 64'd1;
        end
        chk("tmr_flush_req", flush_req, 1);
        chk("tmr_mtime_at_flush", mtime, 64'h11);
        rd(2'd0, 32'h80, "tmr_mstatus_entry");
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("tmr_trap_vld", trap_vld, 1);
        chk("tmr_cause", trap_cause, 32'h8000_0007);
        chk("tmr_epc", trap_epc, 32'h200);
        tick();
        chk("tmr_busy_end", busy, 0);
        wr(2'd2, 32'h1000);
        mret_vld = 1'b1;
        tick();
        mret_vld = 1'b0;
        rd(2'd0, 32'h88, "mret_mstatus");
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | flush_req;
        end
        chk("tmr_no_retrigger", seen, 0);

        // priority: exception beats pending external and timer interrupts
        wr(2'd0, 32'h0);
        wr(2'd1, 32'h880);
        mtime = 64'h2000;
        tick();
        tick();
        wr(2'd0, 32'h8);
        exc_vld = 1'b1; exc_cause = 4'd2; exc_pc = 32'h300;
        ext_irq = 1'b1; resume_pc = 32'h400;
        tick();
        exc_vld = 1'b0;
        chk("prio_flush_req", flush_req, 1);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("prio_cause", trap_cause, 32'h2);
        chk("prio_epc", trap_epc, 32'h300);
        tick();
        chk("prio_busy_end", busy, 0);
        mret_vld = 1'b1;
        tick();
        mret_vld = 1'b0;
        tick();
        chk("prio2_flush_req", flush_req, 1);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("prio2_cause", trap_cause, 32'h8000_000B);
        chk("prio2_epc", trap_epc, 32'h400);
        tick();
        ext_irq = 1'b0;
        mtime = 64'h0;
        wr(2'd1, 32'h0);
        tick();

        // masking: external interrupt held off by MIE and MEIE
        ext_irq = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | flush_req;
        end
        chk("mask_both", seen, 0);
        wr(2'd1, 32'h800);
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | flush_req;
        end
        chk("mask_mie", seen, 0);
        wr(2'd0, 32'h8);
        tick();
        chk("unmask_flush_req", flush_req, 1);
        ext_irq = 1'b0;

        // busy: exception during FLUSH ignored, cfg writes still land
        nt = n_trap;
        exc_vld = 1'b1; exc_cause = 4'd5; exc_pc = 32'h500;
        tick();
        exc_vld = 1'b0;
        chk("busy_flush_hold", flush_req, 1);
        wr(2'd3, 32'hABCD);
        rd(2'd3, 32'hABCD, "busy_cfg_write");
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("busy_cause", trap_cause, 32'h8000_000B);
        chk("busy_epc", trap_epc, 32'h400);
        repeat (5) tick();
        chk("busy_single_trap", n_trap, nt + 1);
        chk("busy_idle", busy, 0);

        // reset in the middle of FLUSH
        exc_vld = 1'b1; exc_cause = 4'd3; exc_pc = 32'h600;
        tick();
        exc_vld = 1'b0;
        chk("rst2_in_flush", flush_req, 1);
        wr(2'd0, 32'h88);
        rd(2'd0, 32'h88, "rst2_mstatus_wr");
        #2;
        rst = 1'b1;
        #1;
        chk("rst2_flush_drop", flush_req, 0);
        chk("rst2_busy", busy, 0);
        rd(2'd0, 32'h0, "rst2_mstatus");
        rd(2'd2, 32'hFFFF_FFFF, "rst2_cmp_lo");
        rd(2'd3, 32'hFFFF_FFFF, "rst2_cmp_hi");
        tick();
        rst = 1'b0;
        nt = n_trap;
        flush_ack = 1'b1;
        repeat (5) tick();
        flush_ack = 1'b0;
        chk("rst2_no_trap", n_trap, nt);
        chk("rst2_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
